// File: rtl/mc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// It owns pc, ir, the retire counter and the request timeout watchdog.
module mc_seq_ctrl #(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c00_0000),
   parameter int unsigned     CNT_W    = 32,
   parameter int unsigned     TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             reset,
   output logic             inst_req,
   output logic [PC_W-1:0]  inst_addr,
   input  logic             inst_ack,
   input  logic [31:0]      inst_rdata,
   output logic             data_req,
   output logic             data_wr,
   input  logic             data_ack,
   input  logic             dec_is_br,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_gr_we,
   input  logic             br_taken,
   input  logic [PC_W-1:0]  br_target,
   output logic [PC_W-1:0]  pc,
   output logic [31:0]      ir,
   output logic             rf_we,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             timeout_err,
   output logic [PC_W-1:0]  debug_wb_pc
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EXE  = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   // Last wait value before the watchdog fires; the TIMEOUT-th unacked cycle halts.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   logic [2:0]       r_state;
   logic [PC_W-1:0]  r_pc;
   logic [31:0]      r_ir;
   logic [CNT_W-1:0] r_retired;
   logic             r_terr;
   logic [PC_W-1:0]  r_dbg_pc;
   logic [15:0]      r_wait;
   logic             r_mem_op;

   logic [2:0]       w_state_nx;
   logic [PC_W-1:0]  w_pc_nx;
   logic [PC_W-1:0]  w_pc4;
   logic [PC_W-1:0]  w_pc_flow;
   logic             w_retire;
   logic             w_ld_ir;
   logic             w_to_halt;
   logic [15:0]      w_wait_nx;

   assign w_pc4     = r_pc + PC_W'(4);
   assign w_pc_flow = br_taken ? br_target : w_pc4;

   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_retire   = 1'b0;
      w_ld_ir    = 1'b0;
      w_to_halt  = 1'b0;
      w_wait_nx  = r_wait;
      case (r_state)
         S_IF: begin
            if (inst_ack) begin
               w_state_nx = S_ID;
               w_ld_ir    = 1'b1;
               w_wait_nx  = '0;
            end else if (r_wait == WAIT_LAST) begin
               w_state_nx = S_HALT;
               w_to_halt  = 1'b1;
            end else begin
               w_wait_nx  = r_wait + 16'd1;
            end
         end
         S_ID: begin
            if (dec_is_br) begin
               w_state_nx = S_IF;
               w_pc_nx    = w_pc_flow;
               w_retire   = 1'b1;
               w_wait_nx  = '0;
            end else begin
               w_state_nx = S_EXE;
            end
         end
         S_EXE: begin
            // Memory class was captured in ID so EXE needs no decode inputs.
            w_state_nx = r_mem_op ? S_MEM : S_WB;
            w_wait_nx  = '0;
         end
         S_MEM: begin
            if (data_ack) begin
               w_wait_nx = '0;
               if (dec_is_store) begin
                  w_state_nx = S_IF;
                  w_pc_nx    = w_pc4;
                  w_retire   = 1'b1;
               end else begin
                  w_state_nx = S_WB;
               end
            end else if (r_wait == WAIT_LAST) begin
               w_state_nx = S_HALT;
               w_to_halt  = 1'b1;
            end else begin
               w_wait_nx  = r_wait + 16'd1;
            end
         end
         S_WB: begin
            w_state_nx = S_IF;
            w_pc_nx    = w_pc_flow;
            w_retire   = 1'b1;
            w_wait_nx  = '0;
         end
         S_HALT: begin
            w_state_nx = S_HALT;
         end
         default: begin
            w_state_nx = S_IF;
            w_wait_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IF;
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_retired <= '0;
         r_terr    <= 1'b0;
         r_dbg_pc  <= '0;
         r_wait    <= '0;
         r_mem_op  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_wait  <= w_wait_nx;
         if (w_ld_ir) begin
            r_ir <= inst_rdata;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         if (w_to_halt) begin
            r_terr <= 1'b1;
         end
         if (r_state == S_WB) begin
            r_dbg_pc <= r_pc;
         end
         if (r_state == S_ID) begin
            r_mem_op <= dec_is_load | dec_is_store;
         end
      end
   end

   assign inst_req    = !reset && (r_state == S_IF);
   assign inst_addr   = r_pc;
   assign data_req    = !reset && (r_state == S_MEM);
   assign data_wr     = data_req && dec_is_store;
   assign rf_we       = !reset && (r_state == S_WB) && dec_gr_we;
   assign pc          = r_pc;
   assign ir          = r_ir;
   assign state       = r_state;
   assign retired     = r_retired;
   assign timeout_err = r_terr;
   assign debug_wb_pc = (r_state == S_WB) ? r_pc : r_dbg_pc;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Randomized instruction-level bench for mc_seq_ctrl with a transaction model.
// A second instance with wrapping pc and a 2-bit retire counter runs in lockstep.
module tb_mc_seq_ctrl;

   localparam int unsigned TO     = 4;
   localparam logic [31:0] RST_PC = 32'h1c00_0000;
   localparam logic [31:0] WRP_PC = 32'hffff_fffc;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_ack, data_ack;
   logic [31:0] inst_rdata;
   logic        dec_is_br, dec_is_load, dec_is_store, dec_gr_we, br_taken;
   logic [31:0] br_target;

   logic        inst_req, data_req, data_wr, rf_we, timeout_err;
   logic [31:0] inst_addr, pc, ir, retired, debug_wb_pc;
   logic [2:0]  state;

   logic        inst_req_w, data_req_w, data_wr_w, rf_we_w, timeout_err_w;
   logic [31:0] inst_addr_w, pc_w, ir_w, debug_wb_pc_w;
   logic [1:0]  retired_w;
   logic [2:0]  state_w;

   int n_chk  = 0;
   int n_fail = 0;
   int n_ins  = 0;

   logic [31:0] m_pc, m_pc2, m_ret, m_ir, m_dbg;

   always #5 clk = ~clk;

   mc_seq_ctrl #(.PC_W(32), .RESET_PC(RST_PC), .CNT_W(32), .TIMEOUT(TO)) u_dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_ack(data_ack),
      .dec_is_br(dec_is_br), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_gr_we(dec_gr_we), .br_taken(br_taken), .br_target(br_target),
      .pc(pc), .ir(ir), .rf_we(rf_we), .state(state), .retired(retired),
      .timeout_err(timeout_err), .debug_wb_pc(debug_wb_pc)
   );

   mc_seq_ctrl #(.PC_W(32), .RESET_PC(WRP_PC), .CNT_W(2), .TIMEOUT(TO)) u_wrap (
      .clk(clk), .reset(reset),
      .inst_req(inst_req_w), .inst_addr(inst_addr_w), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
      .data_req(data_req_w), .data_wr(data_wr_w), .data_ack(data_ack),
      .dec_is_br(dec_is_br), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
      .dec_gr_we(dec_gr_we), .br_taken(br_taken), .br_target(br_target),
      .pc(pc_w), .ir(ir_w), .rf_we(rf_we_w), .state(state_w), .retired(retired_w),
      .timeout_err(timeout_err_w), .debug_wb_pc(debug_wb_pc_w)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      inst_ack = 1'b0;
      data_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_inst_req", inst_req, 0);
      chk("rst_data_req", data_req, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_state", state, 0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_ir", ir, 0);
      chk("rst_retired", retired, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_dbg", debug_wb_pc, 0);
      chk("rst_wrap_pc", pc_w, WRP_PC);
      reset = 1'b0;
      #1;
      chk("post_rst_inst_req", inst_req, 1);
      chk("post_rst_inst_addr", inst_addr, RST_PC);
      m_pc  = RST_PC;
      m_pc2 = WRP_PC;
      m_ret = '0;
      m_ir  = '0;
      m_dbg = '0;
   endtask

   // kind: 0 alu/jirl, 1 branch, 2 load, 3 store. Latencies count request cycles up to and including the ack.
   task automatic run_instr(input int kind, input int f_lat, input int m_lat, input logic taken,
                            input logic [31:0] tgt, input logic gr_we, input logic [31:0] rdata);
      bit   is_br, is_ld, is_st, is_mem, wb, halt_exp, fetched;
      int   cyc, run, rfwe_cnt, dreq_cnt, wr_bad, exp_cyc, exp_dreq;
      logic [31:0] new_pc, new_pc2;
      n_ins++;
      is_br  = (kind == 1);
      is_ld  = (kind == 2);
      is_st  = (kind == 3);
      is_mem = is_ld || is_st;
      wb     = !is_br && !is_st;
      halt_exp = (f_lat > int'(TO)) || (is_mem && m_lat > int'(TO));
      chk($sformatf("i%0d_addr", n_ins), inst_addr, m_pc);
      cyc = 0; run = 0; rfwe_cnt = 0; dreq_cnt = 0; wr_bad = 0; fetched = 0;
      while (cyc < 40) begin
         if (inst_req && fetched) break;
         inst_ack   = 1'b0;
         data_ack   = 1'b0;
         inst_rdata = $urandom;
         if (inst_req) begin
            // Decode outputs are not yet meaningful while the fetch is outstanding.
            {dec_is_br, dec_is_load, dec_is_store, dec_gr_we, br_taken} = 5'($urandom);
            br_target = $urandom;
            run++;
            if (run == f_lat) begin
               inst_ack   = 1'b1;
               inst_rdata = rdata;
               fetched    = 1;
               run        = 0;
            end
         end else begin
            dec_is_br = is_br; dec_is_load = is_ld; dec_is_store = is_st;
            dec_gr_we = gr_we; br_taken = taken; br_target = tgt;
            inst_ack  = 1'($urandom_range(0, 1));
         end
         if (data_req) begin
            dreq_cnt++;
            if (data_wr !== is_st) wr_bad++;
            run++;
            if (run == m_lat) begin
               data_ack = 1'b1;
               run      = 0;
            end
         end else begin
            data_ack = 1'($urandom_range(0, 1));
         end
         if (rf_we) begin
            rfwe_cnt++;
            chk($sformatf("i%0d_wb_pc", n_ins), debug_wb_pc, m_pc);
         end
         @(posedge clk); #1;
         cyc++;
      end
      inst_ack = 1'b0;
      data_ack = 1'b0;
      if (halt_exp) begin
         exp_dreq = (f_lat > int'(TO)) ? 0 : int'(TO);
         chk($sformatf("i%0d_halt_state", n_ins), state, 5);
         chk($sformatf("i%0d_halt_terr", n_ins), timeout_err, 1);
         chk($sformatf("i%0d_halt_ireq", n_ins), inst_req, 0);
         chk($sformatf("i%0d_halt_dreq", n_ins), data_req, 0);
         chk($sformatf("i%0d_halt_rfwe", n_ins), rfwe_cnt, 0);
         chk($sformatf("i%0d_halt_dcnt", n_ins), dreq_cnt, exp_dreq);
         chk($sformatf("i%0d_halt_pc", n_ins), pc, m_pc);
         chk($sformatf("i%0d_halt_ret", n_ins), retired, m_ret);
         chk($sformatf("i%0d_halt_ir", n_ins), ir, (f_lat > int'(TO)) ? m_ir : rdata);
         do_reset();
      end else begin
         exp_cyc  = f_lat + 1 + (is_br ? 0 : 1 + (is_mem ? m_lat : 0) + (wb ? 1 : 0));
         exp_dreq = is_mem ? m_lat : 0;
         new_pc   = (!is_st && taken) ? tgt : m_pc + 32'd4;
         new_pc2  = (!is_st && taken) ? tgt : m_pc2 + 32'd4;
         if (wb) m_dbg = m_pc;
         m_pc  = new_pc;
         m_pc2 = new_pc2;
         m_ret = m_ret + 32'd1;
         m_ir  = rdata;
         chk($sformatf("i%0d_cycles", n_ins), cyc, exp_cyc);
         chk($sformatf("i%0d_rfwe_cnt", n_ins), rfwe_cnt, (wb && gr_we) ? 1 : 0);
         chk($sformatf("i%0d_dreq_cnt", n_ins), dreq_cnt, exp_dreq);
         chk($sformatf("i%0d_data_wr", n_ins), wr_bad, 0);
         chk($sformatf("i%0d_ir", n_ins), ir, rdata);
         chk($sformatf("i%0d_pc", n_ins), pc, m_pc);
         chk($sformatf("i%0d_ret", n_ins), retired, m_ret);
         chk($sformatf("i%0d_dbg", n_ins), debug_wb_pc, m_dbg);
         chk($sformatf("i%0d_terr", n_ins), timeout_err, 0);
         chk($sformatf("i%0d_state", n_ins), state, 0);
         chk($sformatf("i%0d_wrap_pc", n_ins), pc_w, m_pc2);
         chk($sformatf("i%0d_wrap_ret", n_ins), retired_w, m_ret[1:0]);
      end
   endtask

   initial begin
      int k, fl, ml;
      reset = 1'b1; inst_ack = 1'b0; data_ack = 1'b0; inst_rdata = '0;
      dec_is_br = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0;
      dec_gr_we = 1'b0; br_taken = 1'b0; br_target = '0;
      do_reset();
      run_instr(0, 1, 1, 1'b0, 32'h0, 1'b1, 32'h0010_1884);
      run_instr(2, 1, 4, 1'b0, 32'h0, 1'b1, 32'h2880_0085);
      run_instr(1, 1, 1, 1'b1, 32'h1c00_0100, 1'b0, 32'h5800_0485);
      run_instr(3, 4, 4, 1'b0, 32'h0, 1'b0, 32'h2980_0085);
      run_instr(0, 5, 1, 1'b0, 32'h0, 1'b1, 32'h0010_1884);
      run_instr(2, 2, 5, 1'b0, 32'h0, 1'b1, 32'h2880_0085);
      for (int i = 0; i < 80; i++) begin
         k  = int'($urandom_range(0, 3));
         fl = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 4));
         ml = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 4));
         run_instr(k, fl, ml, 1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
                   1'($urandom_range(0, 1)), $urandom);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
